// File: rtl/serial_rx_if.sv
// Link-side bundle for serial_rx_pulse: line input, byte/valid/ack handshake and status flags.
// The receiver takes the slave view; the pin driver and the consumer take the master view.
interface serial_rx_if;
   logic       serial_in;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       rx_ack;
   logic       frame_error;
   logic       overrun;
   logic       busy;

   modport slave (
      input  serial_in,
      input  rx_ack,
      output rx_data,
      output rx_valid,
      output frame_error,
      output overrun,
      output busy
   );

   modport master (
      output serial_in,
      output rx_ack,
      input  rx_data,
      input  rx_valid,
      input  frame_error,
      input  overrun,
      input  busy
   );
endinterface

// File: rtl/serial_rx_pulse.sv
// Receiver for the strobed single-wire link: start strobe, eight data strobes MSB first, stop
// strobe, all BIT_PERIOD clocks apart. The recovered byte is held in a valid/ack register.
module serial_rx_pulse #(
   parameter int unsigned BIT_PERIOD = 106,
   parameter int unsigned CNT_W      = 10
) (
   input logic        clock,
   input logic        reset,
   serial_rx_if.slave rx
);

   localparam logic [1:0] StIdle = 2'd0;
   localparam logic [1:0] StData = 2'd1;
   localparam logic [1:0] StStop = 2'd2;

   localparam logic [CNT_W-1:0] CntLast = CNT_W'(BIT_PERIOD - 1);

   logic [1:0]       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [3:0]       bit_idx_q, bit_idx_d;
   logic [7:0]       shift_q, shift_d;
   logic [7:0]       rx_data_q, rx_data_d;
   logic             rx_valid_q, rx_valid_d;
   logic             frame_error_q, frame_error_d;
   logic             overrun_q, overrun_d;

   logic sample;
   logic stop_sample;
   logic good_stop;
   logic ack_taken;
   logic load_byte;

   // The line is only looked at on the strobe edge; everything in between is ignored.
   assign sample      = (state_q != StIdle) && (cnt_q == CntLast);
   assign stop_sample = (state_q == StStop) && sample;
   assign good_stop   = stop_sample && rx.serial_in;
   assign ack_taken   = rx_valid_q && rx.rx_ack;
   assign load_byte   = good_stop && (!rx_valid_q || rx.rx_ack);

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      bit_idx_d = bit_idx_q;
      shift_d   = shift_q;
      case (state_q)
         StIdle: begin
            if (!rx.serial_in) begin
               state_d   = StData;
               cnt_d     = '0;
               bit_idx_d = '0;
            end
         end
         StData: begin
            cnt_d = sample ? '0 : cnt_q + 1'b1;
            if (sample) begin
               shift_d   = {shift_q[6:0], rx.serial_in};
               bit_idx_d = bit_idx_q + 4'd1;
               if (bit_idx_q == 4'd7) begin
                  state_d = StStop;
               end
            end
         end
         StStop: begin
            cnt_d = sample ? '0 : cnt_q + 1'b1;
            // A low stop symbol is consumed here, never re-used as the next start.
            if (sample) begin
               state_d = StIdle;
            end
         end
         default: begin
            state_d = StIdle;
            cnt_d   = '0;
         end
      endcase
   end

   always_comb begin
      rx_data_d     = load_byte ? shift_q : rx_data_q;
      rx_valid_d    = load_byte || (rx_valid_q && !ack_taken);
      frame_error_d = stop_sample && !rx.serial_in;
      overrun_d     = (good_stop && rx_valid_q && !rx.rx_ack) || (overrun_q && !ack_taken);
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q       <= StIdle;
         cnt_q         <= '0;
         bit_idx_q     <= '0;
         shift_q       <= '0;
         rx_data_q     <= '0;
         rx_valid_q    <= 1'b0;
         frame_error_q <= 1'b0;
         overrun_q     <= 1'b0;
      end else begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         bit_idx_q     <= bit_idx_d;
         shift_q       <= shift_d;
         rx_data_q     <= rx_data_d;
         rx_valid_q    <= rx_valid_d;
         frame_error_q <= frame_error_d;
         overrun_q     <= overrun_d;
      end
   end

   assign rx.rx_data     = rx_data_q;
   assign rx.rx_valid    = rx_valid_q;
   assign rx.frame_error = frame_error_q;
   assign rx.overrun     = overrun_q;
   assign rx.busy        = (state_q != StIdle);

endmodule

// File: doc/serial_rx_pulse.md
Name: serial_rx_pulse

Overview:
- Receiving end of the single-wire serial link driven by the b13-style transmitter.
- Line idles high. Each symbol is a one-cycle strobe spaced a fixed BIT_PERIOD clocks apart: start (0), eight data bits MSB first, then stop (1).
- The block recovers the byte using the same symbol timing, holds it in a valid/ack output register, and flags framing and overrun errors.
- Sits between the link pin and the consumer (host FSM / FIFO).

Parameters:
- BIT_PERIOD, 106: clocks between consecutive symbol strobes (transmitter DelayTime+2). Legal range 2..1023.
- CNT_W, 10: width of the symbol-spacing counter; must satisfy 2^CNT_W > BIT_PERIOD.

Ports:
- clock  input  1  single clock, all state updates on rising edge.
- reset  input  1  asynchronous, active-high; clears all state immediately.
- serial_in  input  1  link line; idle 1, strobes as described.
- rx_data  output  8  last accepted byte; bit7 = first data symbol.
- rx_valid  output  1  rx_data holds an unconsumed byte.
- rx_ack  input  1  consumer accepts rx_data; sampled only while rx_valid=1.
- frame_error  output  1  one-cycle pulse: stop symbol sampled as 0.
- overrun  output  1  sticky: a good frame completed while rx_valid=1 and no ack that cycle.
- busy  output  1  1 whenever FSM is not IDLE.

Behaviour:
- Reset values: rx_data=0, rx_valid=0, frame_error=0, overrun=0, busy=0, FSM=IDLE, cnt=0, bit_idx=0, shift=0. Reset mid-frame abandons the frame with no pulse.
- FSM states: IDLE, DATA, STOP.
- IDLE:
  - On the edge where serial_in=0: go to DATA, cnt=0, bit_idx=0. Call this edge T.
  - serial_in=1 keeps IDLE.
- Counting: in DATA/STOP, cnt increments every edge. When cnt==BIT_PERIOD-1, the symbol is sampled that edge and cnt returns to 0. Symbol k (k=0..7 data, k=8 stop) is therefore sampled exactly at edge T+(k+1)*BIT_PERIOD. serial_in is ignored on all other edges, including glitches.
- DATA:
  - Each sample: shift = {shift[6:0], serial_in}; bit_idx++.
  - After the 8th sample (bit_idx reaches 8): go to STOP.
- STOP, on its sample edge (T+9*BIT_PERIOD), return to IDLE and:
  - serial_in=1 (good frame):
    - If rx_valid=0, or rx_ack=1 that edge: rx_data<=shift, rx_valid<=1.
    - Otherwise: rx_data unchanged, overrun<=1, byte dropped.
  - serial_in=0: frame_error=1 for exactly one cycle; rx_data/rx_valid unchanged. This 0 is NOT taken as a new start; start detection resumes from the next edge.
- Handshake:
  - rx_ack with rx_valid=1 clears rx_valid next edge, unless a good frame loads the same edge (then rx_valid stays 1 with the new byte).
  - rx_ack also clears overrun.
  - rx_ack with rx_valid=0 has no effect.
- Latency: rx_valid rises on edge T+9*BIT_PERIOD, visible the following cycle.
- Back-to-back frames: a start strobe on the edge immediately after the stop sample is accepted.
- busy=1 from edge T through the stop sample edge inclusive; falls after it.
- No reset of in-flight frames on line activity; the receiver never resynchronises mid-frame.

Test Plan:
- BIT_PERIOD=106, start strobe at edge 10, byte 0xA5 MSB first, stop=1 → rx_data=0xA5, rx_valid=1 after edge 964; busy high over edges 10..964; frame_error never asserts.
- BIT_PERIOD=4, byte 0x3C, stop strobe 0 → frame_error pulses one cycle at stop edge; rx_valid stays 0; next frame 0x81 starting one edge later is received correctly.
- BIT_PERIOD=4, frames 0x11 then 0x22 back-to-back, no ack → rx_data=0x11, overrun=1 after second stop; rx_ack → rx_valid=0, overrun=0.
- BIT_PERIOD=4, frame 0x11 held valid, rx_ack asserted exactly on second frame's (0x22) stop edge → rx_data=0x22, rx_valid=1, overrun=0.
- BIT_PERIOD=4, extra 0 glitches between sample edges during frame 0xFF → rx_data=0xFF (glitches ignored).
- Assert reset asynchronously at edge T+5*BIT_PERIOD mid-frame → all outputs 0 immediately; a following clean frame 0x5A is received as 0x5A.
